// File: rtl/phase_sequencer.sv
// One-hot instruction phase generator: decode/exec/rdmem/fetch with optional rdmem skip,
// wait-stated memory phases, mem_ready handshake, halt parking and a retired-instruction count.
module phase_sequencer #(
  parameter int WAIT_CYCLES = 0,
  parameter int USE_READY   = 0,
  parameter int SKIP_RDMEM  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insn_rd,
  input  logic             insn_wr,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             phase_decode,
  output logic             phase_exec,
  output logic             phase_rdmem,
  output logic             phase_fetch,
  output logic             phase_half,
  output logic             step,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    RDMEM  = 3'd3,
    FETCH  = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] wait_cnt;
  logic       mem_done;

  function automatic state_t next_state(input state_t s, input logic rd, input logic hreq);
    case (s)
      INIT:    next_state = FETCH;
      FETCH:   next_state = hreq ? HALT : DECODE;
      DECODE:  next_state = EXEC;
      EXEC:    next_state = (rd || (SKIP_RDMEM == 0)) ? RDMEM : FETCH;
      RDMEM:   next_state = FETCH;
      HALT:    next_state = DECODE;
      default: next_state = INIT;
    endcase
  endfunction

  assign nxt = next_state(state, insn_rd, halt_req);

  // A memory phase may complete only once the wait count has drained; mem_ready seen
  // earlier is deliberately not remembered.
  assign mem_done = (wait_cnt == 4'd0) && ((USE_READY == 0) || mem_ready);

  always_comb begin
    step = 1'b1;
    case (state)
      EXEC:          step = insn_wr ? mem_done : 1'b1;
      RDMEM, FETCH:  step = mem_done;
      HALT:          step = ~halt_req;
      default:       step = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= INIT;
      wait_cnt     <= 4'd0;
      retired      <= '0;
      phase_decode <= 1'b0;
      phase_exec   <= 1'b0;
      phase_rdmem  <= 1'b0;
      phase_fetch  <= 1'b0;
      phase_half   <= 1'b0;
      halted       <= 1'b0;
    end else if (step) begin
      state        <= nxt;
      wait_cnt     <= 4'(WAIT_CYCLES);
      phase_decode <= (nxt == DECODE);
      phase_exec   <= (nxt == EXEC);
      phase_rdmem  <= (nxt == RDMEM);
      phase_fetch  <= (nxt == FETCH);
      phase_half   <= (nxt == DECODE) || (nxt == EXEC);
      halted       <= (nxt == HALT);
      if (state == FETCH) retired <= retired + CNT_W'(1);
    end else if (wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: four parameterisations share one stimulus stream,
// each section resets them all and checks the instance it targets.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst, insn_rd, insn_wr, mem_ready, halt_req;

  // phase vectors are {decode, exec, rdmem, fetch}
  logic [3:0]  ph0, ph1, ph2, ph3;
  logic        hf0, hf1, hf2, hf3;
  logic        st0, st1, st2, st3;
  logic        hl0, hl1, hl2, hl3;
  logic [15:0] rt0, rt2, rt3;
  logic [3:0]  rt1;

  localparam logic [3:0] PN = 4'b0000, PD = 4'b1000, PE = 4'b0100, PR = 4'b0010, PF = 4'b0001;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_sequencer u_def (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .insn_wr(insn_wr), .mem_ready(mem_ready),
    .halt_req(halt_req), .phase_decode(ph0[3]), .phase_exec(ph0[2]), .phase_rdmem(ph0[1]),
    .phase_fetch(ph0[0]), .phase_half(hf0), .step(st0), .halted(hl0), .retired(rt0));

  phase_sequencer #(.SKIP_RDMEM(0), .CNT_W(4)) u_ns (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .insn_wr(insn_wr), .mem_ready(mem_ready),
    .halt_req(halt_req), .phase_decode(ph1[3]), .phase_exec(ph1[2]), .phase_rdmem(ph1[1]),
    .phase_fetch(ph1[0]), .phase_half(hf1), .step(st1), .halted(hl1), .retired(rt1));

  phase_sequencer #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .insn_wr(insn_wr), .mem_ready(mem_ready),
    .halt_req(halt_req), .phase_decode(ph2[3]), .phase_exec(ph2[2]), .phase_rdmem(ph2[1]),
    .phase_fetch(ph2[0]), .phase_half(hf2), .step(st2), .halted(hl2), .retired(rt2));

  phase_sequencer #(.WAIT_CYCLES(1), .USE_READY(1)) u_rdy (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .insn_wr(insn_wr), .mem_ready(mem_ready),
    .halt_req(halt_req), .phase_decode(ph3[3]), .phase_exec(ph3[2]), .phase_rdmem(ph3[1]),
    .phase_fetch(ph3[0]), .phase_half(hf3), .step(st3), .halted(hl3), .retired(rt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves every instance in its INIT cycle with rst released.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; insn_rd = 1'b0; insn_wr = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    tick();
    chk("rst_phase", 32'(ph0), 32'(PN));
    chk("rst_half", 32'(hf0), 0);
    chk("rst_step", 32'(st0), 1);
    chk("rst_halted", 32'(hl0), 0);
    chk("rst_retired", 32'(rt0), 0);

    // Defaults, non-reading instructions: INIT, FETCH, DECODE, EXEC, FETCH, DECODE
    rst = 1'b1; #1;
    tick(); chk("s1_f1", 32'(ph0), 32'(PF)); chk("s1_f1_step", 32'(st0), 1);
    chk("s1_f1_half", 32'(hf0), 0); chk("s1_f1_ret", 32'(rt0), 0);
    tick(); chk("s1_d1", 32'(ph0), 32'(PD)); chk("s1_d1_half", 32'(hf0), 1);
    chk("s1_ret1", 32'(rt0), 1);
    tick(); chk("s1_e1", 32'(ph0), 32'(PE)); chk("s1_e1_step", 32'(st0), 1);
    tick(); chk("s1_f2", 32'(ph0), 32'(PF));
    tick(); chk("s1_d2", 32'(ph0), 32'(PD)); chk("s1_ret2", 32'(rt0), 2);

    // Reading instruction visits RDMEM
    insn_rd = 1'b1;
    tick(); chk("s2_e", 32'(ph0), 32'(PE));
    tick(); chk("s2_r", 32'(ph0), 32'(PR)); chk("s2_r_step", 32'(st0), 1);
    insn_rd = 1'b0;
    tick(); chk("s2_f", 32'(ph0), 32'(PF));
    tick(); chk("s2_d", 32'(ph0), 32'(PD)); chk("s2_ret", 32'(rt0), 3);

    // SKIP_RDMEM=0 visits RDMEM even for non-reads; CNT_W=4 wraps after 16
    do_reset();
    tick(); chk("s3_f", 32'(ph1), 32'(PF));
    tick(); chk("s3_d", 32'(ph1), 32'(PD));
    tick(); chk("s3_e", 32'(ph1), 32'(PE));
    tick(); chk("s3_r", 32'(ph1), 32'(PR));
    tick(); chk("s3_f2", 32'(ph1), 32'(PF));
    tick(); chk("s3_d2", 32'(ph1), 32'(PD)); chk("s3_ret2", 32'(rt1), 2);
    for (int i = 0; i < 15 * 4; i++) tick();
    chk("s3_wrap_phase", 32'(ph1), 32'(PD));
    chk("s3_wrap_ret", 32'(rt1), 1);

    // WAIT_CYCLES=2 with a writing instruction: EXEC and FETCH last 3 cycles each
    insn_wr = 1'b1;
    do_reset();
    tick(); chk("s4_f1", 32'(ph2), 32'(PF)); chk("s4_f1_step", 32'(st2), 0);
    tick(); chk("s4_f2", 32'(ph2), 32'(PF)); chk("s4_f2_step", 32'(st2), 0);
    tick(); chk("s4_f3", 32'(ph2), 32'(PF)); chk("s4_f3_step", 32'(st2), 1);
    tick(); chk("s4_d", 32'(ph2), 32'(PD)); chk("s4_d_step", 32'(st2), 1);
    tick(); chk("s4_e1", 32'(ph2), 32'(PE)); chk("s4_e1_step", 32'(st2), 0);
    tick(); chk("s4_e2", 32'(ph2), 32'(PE)); chk("s4_e2_step", 32'(st2), 0);
    tick(); chk("s4_e3", 32'(ph2), 32'(PE)); chk("s4_e3_step", 32'(st2), 1);
    tick(); chk("s4_fx", 32'(ph2), 32'(PF)); chk("s4_fx_step", 32'(st2), 0);
    insn_wr = 1'b0;

    // USE_READY=1, WAIT_CYCLES=1
    mem_ready = 1'b1;
    do_reset();
    tick(); chk("s5_f1", 32'(ph3), 32'(PF)); chk("s5_f1_step", 32'(st3), 0);
    tick(); chk("s5_f2", 32'(ph3), 32'(PF)); chk("s5_f2_step", 32'(st3), 1);
    tick(); chk("s5_d", 32'(ph3), 32'(PD));
    tick(); chk("s5_e", 32'(ph3), 32'(PE));
    tick(); chk("s5_g1", 32'(ph3), 32'(PF)); chk("s5_g1_step", 32'(st3), 0);
    mem_ready = 1'b0; #1;
    tick(); chk("s5_g2_step", 32'(st3), 0);
    tick(); chk("s5_g3_step", 32'(st3), 0);
    tick(); chk("s5_g4", 32'(ph3), 32'(PF)); chk("s5_g4_step", 32'(st3), 0);
    tick(); mem_ready = 1'b1; #1;
    chk("s5_g5", 32'(ph3), 32'(PF)); chk("s5_g5_step", 32'(st3), 1);
    tick(); chk("s5_d2", 32'(ph3), 32'(PD)); chk("s5_ret", 32'(rt3), 2);
    mem_ready = 1'b0;

    // Halt after a fetch, resume straight into DECODE
    do_reset();
    halt_req = 1'b1;
    tick(); chk("s6_f", 32'(ph0), 32'(PF));
    tick(); chk("s6_h", 32'(ph0), 32'(PN)); chk("s6_halted", 32'(hl0), 1);
    chk("s6_h_step", 32'(st0), 0); chk("s6_h_half", 32'(hf0), 0);
    chk("s6_h_ret", 32'(rt0), 1);
    tick(); tick(); tick();
    chk("s6_h4", 32'(ph0), 32'(PN)); chk("s6_h4_ret", 32'(rt0), 1);
    halt_req = 1'b0; #1;
    chk("s6_rel_step", 32'(st0), 1);
    tick(); chk("s6_d", 32'(ph0), 32'(PD)); chk("s6_d_halted", 32'(hl0), 0);
    chk("s6_d_ret", 32'(rt0), 1);

    // Reset in the 2nd wait cycle of RDMEM aborts to INIT
    insn_rd = 1'b1;
    do_reset();
    tick(); tick(); tick();
    tick(); chk("s7_d", 32'(ph2), 32'(PD)); chk("s7_ret", 32'(rt2), 1);
    tick(); chk("s7_e", 32'(ph2), 32'(PE));
    tick(); chk("s7_r1", 32'(ph2), 32'(PR));
    tick(); chk("s7_r2", 32'(ph2), 32'(PR)); chk("s7_r2_step", 32'(st2), 0);
    rst = 1'b0;
    tick(); chk("s7_init", 32'(ph2), 32'(PN)); chk("s7_init_ret", 32'(rt2), 0);
    chk("s7_init_step", 32'(st2), 1);
    rst = 1'b1; insn_rd = 1'b0; #1;
    tick(); chk("s7_f", 32'(ph2), 32'(PF));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
